// File: rtl/cic_decim_comb.sv
// rtl/cic_decim_comb.sv - CIC decimator: keeps one of every R valid samples, then applies the first comb stage y = x[k] - x[k-M].
module cic_decim_comb #(
    parameter int WIDTH = 16,
    parameter int R     = 8,
    parameter int M     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic             x_valid,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             primed
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int PW = $clog2(M + 1);
    localparam logic [CW-1:0] LAST_PHASE = CW'(R - 1);
    localparam logic [PW-1:0] FULL_HIST  = PW'(M);

    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_cap_cnt;
    logic [WIDTH-1:0] r_d [M];
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic             r_primed;
    logic             w_capture;

    assign w_capture = x_valid && (r_cnt == LAST_PHASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cap_cnt <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_primed  <= 1'b0;
            for (int i = 0; i < M; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            r_y_valid <= w_capture;
            if (x_valid) begin
                r_cnt <= (r_cnt == LAST_PHASE) ? '0 : r_cnt + CW'(1);
            end
            if (w_capture) begin
                // Plain modulo subtraction: a wrapped integrator still yields the true difference.
                r_y    <= x - r_d[M-1];
                r_d[0] <= x;
                for (int i = 1; i < M; i++) begin
                    r_d[i] <= r_d[i-1];
                end
                if (r_cap_cnt == FULL_HIST) begin
                    r_primed <= 1'b1;
                end else begin
                    r_cap_cnt <= r_cap_cnt + PW'(1);
                end
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign primed  = r_primed;

endmodule
